// File: rtl/pll_lock_monitor_if.sv
// Bundles the lock inputs, sticky-clear strobes and conditioned status/irq of pll_lock_monitor.
// Handshake: none; lock_async is free-running async, clear_lost is a clk-synchronous level, status/irq are registered.
interface pll_lock_monitor_if #(
  parameter int N_PLL = 4
);
  logic [N_PLL-1:0] lock_async;
  logic [N_PLL-1:0] clear_lost;
  logic [7:0]       status;
  logic             irq;

  modport master (
    output lock_async,
    output clear_lost,
    input  status,
    input  irq
  );

  modport slave (
    input  lock_async,
    input  clear_lost,
    output status,
    output irq
  );
endinterface

// File: rtl/pll_lock_monitor.sv
// Synchronizes and debounces up to four PLL lock inputs and keeps sticky loss-of-lock flags.
// Optional loss interrupt register enabled by defining PLL_LOCK_MONITOR_IRQ_EN.
module pll_lock_monitor #(
  parameter int N_PLL           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  pll_lock_monitor_if.slave  bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_PLL-1:0] sync_q [SYNC_STAGES];
  logic [N_PLL-1:0] sync_d [SYNC_STAGES];
  logic [CW-1:0]    cnt_q  [N_PLL];
  logic [CW-1:0]    cnt_d  [N_PLL];
  logic [N_PLL-1:0] stable_q, stable_d;
  logic [N_PLL-1:0] lost_q, lost_d;
  logic [N_PLL-1:0] sync_last;
  logic [N_PLL-1:0] fall;
  logic [7:0]       status_d;

  always_comb begin
    sync_d[0] = bus.lock_async;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];

  // The count only advances while the synced level disagrees with the accepted one;
  // reaching the terminal value accepts the new level and restarts from zero.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N_PLL; i++) begin
      cnt_d[i] = '0;
      if (sync_last[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync_last[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // A fall is taken from registered old/new values, so it can never fire on a rise
  // and never fires for a channel that was not yet locked. Set beats clear.
  assign fall   = stable_q & ~stable_d;
  assign lost_d = fall | (lost_q & ~bus.clear_lost);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      for (int i = 0; i < N_PLL; i++) begin
        cnt_q[i] <= '0;
      end
      stable_q <= '0;
      lost_q   <= '0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      for (int i = 0; i < N_PLL; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      stable_q <= stable_d;
      lost_q   <= lost_d;
    end
  end

  always_comb begin
    status_d               = '0;
    status_d[N_PLL-1:0]    = stable_q;
    status_d[N_PLL+3:4]    = lost_q;
  end

  assign bus.status = status_d;

`ifdef PLL_LOCK_MONITOR_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = |lost_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign bus.irq = irq_q;
`else
  assign bus.irq = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Randomized and directed bench for pll_lock_monitor against a cycle-level behavioural model.
// Builds with or without PLL_LOCK_MONITOR_IRQ_EN; the model follows the same macro.
module tb_pll_lock_monitor;

  localparam int N = 4;
  localparam int S = 2;
  localparam int D = 32;
  localparam int LAT = S + D;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  pll_lock_monitor_if #(.N_PLL(N)) bus ();

  pll_lock_monitor #(
    .N_PLL           (N),
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model: the synchronizer is a plain delay line of past input samples,
  // and a channel accepts a new level after D consecutive disagreeing cycles.
  logic [N-1:0] m_hist [$];
  int           m_run [N];
  logic [N-1:0] m_stable, m_lost, m_fell, m_synced, m_old_lost;
  logic         m_irq;
  logic [7:0]   m_status;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hist = {};
      for (int k = 0; k < S; k++) m_hist.push_back('0);
      for (int i = 0; i < N; i++) m_run[i] = 0;
      m_stable = '0;
      m_lost   = '0;
      m_irq    = 1'b0;
    end else begin
      m_synced   = m_hist[S-1];
      m_old_lost = m_lost;
      m_fell     = '0;
      for (int i = 0; i < N; i++) begin
        if (m_synced[i] == m_stable[i]) begin
          m_run[i] = 0;
        end else begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == D) begin
            m_run[i]    = 0;
            m_fell[i]   = m_stable[i];
            m_stable[i] = m_synced[i];
          end
        end
      end
      m_lost = m_fell | (m_lost & ~bus.clear_lost);
      m_hist.push_front(bus.lock_async);
      void'(m_hist.pop_back());
`ifdef PLL_LOCK_MONITOR_IRQ_EN
      m_irq = |m_old_lost;
`else
      m_irq = 1'b0;
`endif
    end
  end

  assign m_status = {m_lost, m_stable};

  task automatic test_reset();
    bus.lock_async = 4'hF;
    bus.clear_lost = 4'h0;
    reset_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.status !== 8'h00 || bus.irq !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_hold cyc %0d: status=%h irq=%b expected 00 0", c, bus.status, bus.irq);
      end
    end
    reset_n = 1'b1;
    for (int c = 1; c <= LAT + 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.status !== ((c >= LAT) ? 8'h0F : 8'h00) || bus.status !== m_status || bus.irq !== m_irq) begin
        n_errors++;
        $display("FAIL reset_release cyc %0d: status=%h irq=%b expected %h %b", c, bus.status, bus.irq,
                 (c >= LAT) ? 8'h0F : 8'h00, m_irq);
      end
    end
  endtask

  task automatic test_glitch();
    for (int c = 0; c < LAT + 6; c++) begin
      bus.lock_async = (c < D - 2) ? 4'hE : 4'hF;
      @(negedge clk);
      n_checks++;
      if (bus.status !== 8'h0F || bus.status !== m_status || bus.irq !== m_irq) begin
        n_errors++;
        $display("FAIL glitch cyc %0d: status=%h irq=%b expected 0f %b", c, bus.status, bus.irq, m_irq);
      end
    end
  endtask

  task automatic test_loss_ch1();
    bus.lock_async = 4'hD;
    for (int c = 1; c <= LAT + 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.status !== ((c >= LAT) ? 8'h2D : 8'h0F) || bus.status !== m_status || bus.irq !== m_irq) begin
        n_errors++;
        $display("FAIL loss_ch1 cyc %0d: status=%h irq=%b expected %h %b", c, bus.status, bus.irq,
                 (c >= LAT) ? 8'h2D : 8'h0F, m_irq);
      end
    end
  endtask

  task automatic test_clear();
    bus.clear_lost = 4'h2;
    @(negedge clk);
    n_checks++;
    if (bus.status !== 8'h0D || bus.status !== m_status || bus.irq !== m_irq) begin
      n_errors++;
      $display("FAIL clear_pulse: status=%h irq=%b expected 0d %b", bus.status, bus.irq, m_irq);
    end
    bus.clear_lost = 4'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.status !== 8'h0D || bus.irq !== 1'b0 || bus.status !== m_status) begin
        n_errors++;
        $display("FAIL clear_after cyc %0d: status=%h irq=%b expected 0d 0", c, bus.status, bus.irq);
      end
    end
  endtask

  task automatic test_set_wins();
    bus.lock_async = 4'h9;
    bus.clear_lost = 4'h4;
    for (int c = 1; c <= LAT + 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.status !== ((c < LAT) ? 8'h0D : (c == LAT) ? 8'h49 : 8'h09) ||
          bus.status !== m_status || bus.irq !== m_irq) begin
        n_errors++;
        $display("FAIL set_wins cyc %0d: status=%h irq=%b model %h %b", c, bus.status, bus.irq, m_status, m_irq);
      end
    end
    bus.clear_lost = 4'h0;
  endtask

  task automatic test_reset_mid();
    bus.lock_async = 4'hF;
    for (int c = 0; c < D / 2; c++) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.status !== 8'h00 || bus.irq !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid: status=%h irq=%b expected 00 0", bus.status, bus.irq);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 1; c <= LAT + 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.status !== ((c >= LAT) ? 8'h0F : 8'h00) || bus.status !== m_status) begin
        n_errors++;
        $display("FAIL reset_mid_relock cyc %0d: status=%h expected %h", c, bus.status,
                 (c >= LAT) ? 8'h0F : 8'h00);
      end
    end
  endtask

  task automatic test_random();
    int rem = 0;
    for (int c = 0; c < 3000; c++) begin
      if (rem == 0) begin
        bus.lock_async = N'($urandom_range(0, 15));
        rem = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : $urandom_range(D - 3, 2 * D);
      end
      rem--;
      bus.clear_lost = ($urandom_range(0, 9) == 0) ? N'($urandom_range(0, 15)) : '0;
      @(negedge clk);
      n_checks++;
      if (bus.status !== m_status || bus.irq !== m_irq) begin
        n_errors++;
        $display("FAIL random cyc %0d: status=%h irq=%b expected %h %b", c, bus.status, bus.irq, m_status, m_irq);
      end
    end
    bus.clear_lost = '0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_loss_ch1();
    test_clear();
    test_set_wins();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_monitor.md
Name: pll_lock_monitor

Overview:
Conditions the raw, asynchronous PLL lock indicators before CPU software sees them. Each lock input passes through a synchronizer and a debounce filter. The block also records any loss of lock in a sticky flag.
The 8-bit status output drives the 8-bit input port of the NIOS PLL-lock PIO directly. Software reads debounced lock state and sticky loss flags in one register read.

Parameters:
N_PLL, 4, number of monitored PLL lock inputs; legal range 1..4
SYNC_STAGES, 2, synchronizer flop depth per input; legal range 2..4
DEBOUNCE_CYCLES, 1024, consecutive cycles a synced level must hold before it is accepted; legal range 2..65535; counter width = clog2(DEBOUNCE_CYCLES)

Ports:
clk  in  1  system clock (same clock as the PIO)
reset_n  in  1  asynchronous active-low reset
lock_async  in  N_PLL  raw PLL locked signals, asynchronous to clk
clear_lost  in  N_PLL  per-channel sticky-clear strobe, synchronous to clk, active high
status  out  8  [N_PLL-1:0] = stable lock, [N_PLL+3:4] = sticky lost, all other bits 0
irq  out  1  loss-of-lock interrupt (see Optional Feature)

Behaviour:
- Reset (reset_n low, asynchronous):
  - Clears all synchronizer flops, debounce counters, stable bits and lost bits.
  - status = 8'h00, irq = 0.
  - Reset released mid-debounce discards partial counts.
- Synchronizer:
  - SYNC_STAGES flops per channel. sync[i] is the last stage.
  - No cross-channel coherence is required.
- Debounce, per channel i (state: stable[i], cnt[i]):
  - If sync[i] == stable[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: stable[i] <= sync[i], cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i] + 1.
  - stable[i] changes on the clock edge ending the DEBOUNCE_CYCLES-th consecutive cycle in which sync[i] != stable[i].
  - Any glitch back to the stable level restarts the count from 0.
  - Total latency from a clean lock_async edge to status: SYNC_STAGES + DEBOUNCE_CYCLES cycles.
  - Rise and fall are filtered identically.
- Loss detection:
  - fall[i] = stable[i] goes 1->0 on this edge. This is decided from the registered old and new values, so a rise never sets lost.
  - A channel that has never locked cannot set lost.
- Sticky lost[i]:
  - If fall[i]: lost[i] <= 1.
  - Else if clear_lost[i]: lost[i] <= 0.
  - Set wins over a simultaneous clear.
  - Clear is level-sensitive; holding it high keeps lost low except on a fall cycle.
  - Clearing does not affect stable or cnt.
- status is driven directly from registers, with no combinational path from inputs. Unused bits for N_PLL < 4 are constant 0.
- The counter never wraps: it saturates by reset-to-0 at the terminal count.

Optional Feature:
Macro: PLL_LOCK_MONITOR_IRQ_EN
- Defined: irq is a register set to the OR of lost[N_PLL-1:0] one cycle after any lost bit is set. It clears one cycle after all lost bits are cleared.
- Not defined: irq is tied to constant 0 and no irq logic is synthesized. status behaviour is identical in both builds.

Test Plan:
- Reset with lock_async=4'hF held -> status=8'h00 throughout reset; after release, status=8'h0F exactly SYNC_STAGES+DEBOUNCE_CYCLES cycles after the first sync edge; lost=0.
- Ch0 locked, then lock_async[0] drops for DEBOUNCE_CYCLES-2 cycles and returns -> status stays 8'h0F, cnt[0] back to 0.
- Ch1 locked, then held low -> after the full latency status=8'h2D (stable[1]=0, lost[1]=1); with the macro defined, irq=1 on the next cycle.
- clear_lost=4'h2 pulsed for 1 cycle after the previous scenario -> status=8'h0D next cycle; irq=0 one cycle later.
- clear_lost[2] held high on the same edge ch2's stable falls -> lost[2]=1 (set wins); it clears on the next cycle because clear is still high.
- N_PLL=2 build, all inputs high -> status=8'h03; a loss on ch0 -> status=8'h12; bits 7:6 and 3:2 are never 1. Reset asserted mid-debounce -> status=8'h00 immediately.
